// File: rtl/sw_operand_capture_pkg.sv
// Shared definitions for the switch/button operand capture front end.
// Holds the FSM state encoding, the switch field positions and a helper
// that slices a synchronized switch word into its operand fields.
package sw_operand_capture_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  // Switch field positions.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 14;
  localparam int B_HI   = 7;
  localparam int B_LO   = 4;
  localparam int A_HI   = 3;
  localparam int A_LO   = 0;

  // One captured transaction.
  typedef struct packed {
    logic [1:0] code;
    logic [3:0] b;
    logic [3:0] a;
  } operand_t;

  // Slice a synchronized switch word into opcode and operands.
  function automatic operand_t unpackSwitches(input logic [15:0] swWord);
    operand_t fields;
    fields.code = swWord[OPC_HI:OPC_LO];
    fields.b    = swWord[B_HI:B_LO];
    fields.a    = swWord[A_HI:A_LO];
    return fields;
  endfunction

endpackage

// File: rtl/sw_operand_capture_btn_debounce.sv
// Button conditioner: two-flop synchronizer, saturating debounce counter,
// debounced level and a one-cycle press pulse on each clean 0->1 change.
// Written generically so the other board buttons can reuse it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_evt_o
);

  // The level toggles on the edge where the counter sits at this value
  // while the synchronized input still disagrees with the level.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btnMeta_q;
  logic             btnSync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta_q <= 1'b0;
      btnSync_q <= 1'b0;
    end else begin
      btnMeta_q <= btn_i;
      btnSync_q <= btnMeta_q;
    end
  end

  // Next-state for counter, level and press pulse; the counter clears on
  // agreement and on the toggle edge, so it never passes LIMIT.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (btnSync_q != level_q) begin
      if (cnt_q == LIMIT) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o     = level_q;
  assign press_evt_o = press_q;

endmodule

// File: rtl/sw_operand_capture.sv
// Input front end for the switch/7-segment datapath. Synchronizes the
// switches, debounces the centre button and, on each clean press, captures
// opcode and operands into a valid/ready transaction for the operator stage.
module sw_operand_capture
  import sw_operand_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        btnc,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  op_code,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic        busy
);

  logic [15:0] swMeta_q;
  logic [15:0] swSync_q;
  logic        btnLevel;
  logic        pressEvt;
  operand_t    swFields;
  logic        sw_unused;

  state_e      state_q;
  logic        valid_q;
  logic        busy_q;
  logic [1:0]  code_q;
  logic [3:0]  a_q;
  logic [3:0]  b_q;

  // Centre button conditioning.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btnc (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btnc),
    .level_o    (btnLevel),
    .press_evt_o(pressEvt)
  );

  // Two-flop synchronizer on every switch; switches are sampled only at a
  // press, so they need no debouncing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta_q <= '0;
      swSync_q <= '0;
    end else begin
      swMeta_q <= sw;
      swSync_q <= swMeta_q;
    end
  end

  assign swFields  = unpackSwitches(swSync_q);
  assign sw_unused = ^swSync_q[13:8];

  // Capture FSM with registered valid, busy and data; presses outside IDLE
  // are dropped, and WAIT_REL keeps a held button from re-triggering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pressEvt) begin
            code_q  <= swFields.code;
            b_q     <= swFields.b;
            a_q     <= swFields.a;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= VALID;
          end
        end
        VALID: begin
          if (op_ready) begin
            valid_q <= 1'b0;
            if (btnLevel) begin
              state_q <= WAIT_REL;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        WAIT_REL: begin
          if (!btnLevel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_valid = valid_q;
  assign op_code  = code_q;
  assign op_a     = a_q;
  assign op_b     = b_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sw_operand_capture.sv
// Self-checking bench for sw_operand_capture with a short debounce window.
// Stimulus pushes expected transactions; a negedge monitor pops and checks
// each completed handshake.
module tb_sw_operand_capture;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] b;
    logic [3:0] a;
  } expTxn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic        btnc;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic        busy;

  int      testsRun    = 0;
  int      testsFailed = 0;
  int      transfers   = 0;
  expTxn_t expQueue[$];

  // 100 MHz clock.
  always #5 clk = ~clk;

  sw_operand_capture #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .btnc    (btnc),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_code (op_code),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] swVal, input logic btnVal,
                               input logic readyVal);
    sw       = swVal;
    btnc     = btnVal;
    op_ready = readyVal;
  endtask

  task automatic waitValid(input string name);
    int k = 0;
    while (!op_valid && k < 20) begin
      stepCycles(1);
      k++;
    end
    checkOutput(name, {31'd0, op_valid}, 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    btnc     = 1'b0;
    op_ready = 1'b0;
    while (busy && k < 20) begin
      stepCycles(1);
      k++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every completed handshake must match the next expected entry.
  always @(negedge clk) begin
    expTxn_t e;
    if (rst_n && op_valid && op_ready) begin
      transfers++;
      if (expQueue.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_txn: got code=%0h b=%0h a=%0h, expected none",
                 op_code, op_b, op_a);
      end else begin
        e = expQueue.pop_front();
        checkOutput("txn_code", {30'd0, op_code}, {30'd0, e.code});
        checkOutput("txn_b", {28'd0, op_b}, {28'd0, e.b});
        checkOutput("txn_a", {28'd0, op_a}, {28'd0, e.a});
      end
    end
  end

  initial begin
    bit holdValid;
    bit holdData;
    bit sawAny;
    int xferBefore;
    int validCycles;

    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("rst_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("rst_code", {30'd0, op_code}, 32'd0);
    checkOutput("rst_a", {28'd0, op_a}, 32'd0);
    checkOutput("rst_b", {28'd0, op_b}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    // 1: clean press, op_valid on edge 7, release returns to IDLE.
    rst_n = 1'b1;
    expQueue.push_back('{code: 2'd1, b: 4'h3, a: 4'h5});
    applyStimulus(16'h4035, 1'b1, 1'b0);
    stepCycles(6);
    checkOutput("t1_valid_e6", {31'd0, op_valid}, 32'd0);
    stepCycles(1);
    checkOutput("t1_valid_e7", {31'd0, op_valid}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_code", {30'd0, op_code}, 32'd1);
    checkOutput("t1_b", {28'd0, op_b}, 32'h3);
    checkOutput("t1_a", {28'd0, op_a}, 32'h5);
    applyStimulus(16'h4035, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("t1_valid_after", {31'd0, op_valid}, 32'd0);
    checkOutput("t1_waitrel_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_code_retained", {30'd0, op_code}, 32'd1);
    applyStimulus(16'h4035, 1'b0, 1'b0);
    stepCycles(5);
    checkOutput("t1_busy_release5", {31'd0, busy}, 32'd1);
    stepCycles(2);
    checkOutput("t1_busy_release7", {31'd0, busy}, 32'd0);

    // 2: glitches of 1, 2 and 3 cycles never produce a capture.
    for (int p = 1; p <= 3; p++) begin
      sawAny = 1'b0;
      btnc = 1'b1;
      for (int c = 0; c < p; c++) begin
        stepCycles(1);
        sawAny |= op_valid | busy;
      end
      btnc = 1'b0;
      for (int c = 0; c < 5; c++) begin
        stepCycles(1);
        sawAny |= op_valid | busy;
      end
      checkOutput($sformatf("t2_glitch_%0d", p), {31'd0, sawAny}, 32'd0);
    end

    // 3: backpressure holds data stable while switches change.
    expQueue.push_back('{code: 2'd3, b: 4'hA, a: 4'h9});
    applyStimulus(16'hC0A9, 1'b1, 1'b0);
    waitValid("t3_valid");
    sw = 16'h0000;
    holdValid = 1'b1;
    holdData  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      stepCycles(1);
      holdValid &= op_valid;
      holdData  &= (op_code == 2'd3) && (op_b == 4'hA) && (op_a == 4'h9);
    end
    checkOutput("t3_hold_valid", {31'd0, holdValid}, 32'd1);
    checkOutput("t3_hold_data", {31'd0, holdData}, 32'd1);
    op_ready = 1'b1;
    stepCycles(1);
    op_ready = 1'b0;
    checkOutput("t3_valid_after", {31'd0, op_valid}, 32'd0);
    waitIdle("t3_idle");

    // 4: release and re-press during VALID is dropped; later press captures.
    expQueue.push_back('{code: 2'd1, b: 4'h2, a: 4'h1});
    applyStimulus(16'h4021, 1'b1, 1'b0);
    waitValid("t4_valid");
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    stepCycles(8);
    btnc = 1'b1;
    stepCycles(8);
    checkOutput("t4_still_valid", {31'd0, op_valid}, 32'd1);
    checkOutput("t4_held_a", {28'd0, op_a}, 32'h1);
    xferBefore = transfers;
    op_ready = 1'b1;
    stepCycles(1);
    op_ready = 1'b0;
    stepCycles(10);
    checkOutput("t4_one_txn", transfers - xferBefore, 32'd1);
    checkOutput("t4_no_revalid", {31'd0, op_valid}, 32'd0);
    waitIdle("t4_idle");
    expQueue.push_back('{code: 2'd2, b: 4'h1, a: 4'h2});
    applyStimulus(16'h8012, 1'b1, 1'b0);
    waitValid("t4_second_valid");
    op_ready = 1'b1;
    stepCycles(1);
    waitIdle("t4_second_idle");

    // 5: reset mid-VALID clears asynchronously; held button recaptures.
    applyStimulus(16'h4035, 1'b1, 1'b0);
    waitValid("t5_valid");
    rst_n = 1'b0;
    #2;
    checkOutput("t5_rst_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("t5_rst_code", {30'd0, op_code}, 32'd0);
    checkOutput("t5_rst_a", {28'd0, op_a}, 32'd0);
    checkOutput("t5_rst_b", {28'd0, op_b}, 32'd0);
    checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQueue.push_back('{code: 2'd1, b: 4'h3, a: 4'h5});
    stepCycles(6);
    checkOutput("t5_valid_e6", {31'd0, op_valid}, 32'd0);
    stepCycles(1);
    checkOutput("t5_valid_e7", {31'd0, op_valid}, 32'd1);
    op_ready = 1'b1;
    stepCycles(1);
    waitIdle("t5_idle");

    // 6: ready tied high gives a single-cycle valid.
    expQueue.push_back('{code: 2'd1, b: 4'hF, a: 4'hF});
    applyStimulus(16'h40FF, 1'b1, 1'b1);
    validCycles = 0;
    for (int c = 0; c < 15; c++) begin
      stepCycles(1);
      if (op_valid) validCycles++;
    end
    checkOutput("t6_valid_cycles", validCycles, 32'd1);
    waitIdle("t6_idle");

    stepCycles(3);
    checkOutput("pending_txns", expQueue.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
